// File: rtl/actfunc_pla_pipe_if.sv
// Stream and coefficient-table bus for actfunc_pla_pipe: sample in, result out,
// and the per-segment slope/intercept write port.
interface actfunc_pla_pipe_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] x;
   logic              hi_mode;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] y;
   logic              cfg_we;
   logic [ADDR_W-1:0] cfg_addr;
   logic [DATA_W-1:0] cfg_slope;
   logic [DATA_W-1:0] cfg_icpt;

   modport master (
      output in_valid, x, hi_mode, out_ready, cfg_we, cfg_addr, cfg_slope, cfg_icpt,
      input  in_ready, out_valid, y
   );

   modport slave (
      input  in_valid, x, hi_mode, out_ready, cfg_we, cfg_addr, cfg_slope, cfg_icpt,
      output in_ready, out_valid, y
   );
endinterface

// File: rtl/actfunc_pla_pipe.sv
// Three-stage piecewise-linear activation unit with programmable slope/intercept table.
// Define ACTFUNC_PLA_SAT_CNT_EN to add the sat_cnt clipped-result counter output.
module actfunc_pla_pipe #(
   parameter int DATA_W     = 16,
   parameter int FRAC_W     = 8,
   parameter int SEG_N      = 16,
   parameter int SEG_W_LOG2 = 8,
   parameter int X_LO       = -2048
) (
   input  logic               clk,
   input  logic               rst,
   actfunc_pla_pipe_if.slave  bus
`ifdef ACTFUNC_PLA_SAT_CNT_EN
   ,
   output logic [15:0]        sat_cnt
`endif
);
   localparam int ADDR_W = $clog2(SEG_N);
   localparam int PROD_W = 2 * DATA_W;
   localparam int SUM_W  = 2 * DATA_W + 2;

   localparam logic signed [DATA_W:0]    X_LO_EXT = (DATA_W+1)'(X_LO);
   localparam logic        [DATA_W:0]    RANGE_U  = (DATA_W+1)'(SEG_N << SEG_W_LOG2);
   localparam logic        [DATA_W-1:0]  ONE_Y    = {{(DATA_W-1){1'b0}}, 1'b1} << FRAC_W;
   localparam logic signed [SUM_W-1:0]   RND      = {{(SUM_W-1){1'b0}}, 1'b1} << (FRAC_W-1);

   typedef enum logic [1:0] {
      CLS_IN = 2'd0,
      CLS_LO = 2'd1,
      CLS_HI = 2'd2
   } cls_t;

   function automatic logic fits_fn(input logic signed [SUM_W-1:0] v);
      return (&v[SUM_W-1:DATA_W-1]) || !(|v[SUM_W-1:DATA_W-1]);
   endfunction

   function automatic logic [DATA_W-1:0] sat_fn(input logic signed [SUM_W-1:0] v);
      logic [DATA_W-1:0] res;
      if (fits_fn(v)) begin
         res = v[DATA_W-1:0];
      end else if (v[SUM_W-1]) begin
         res = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         res = {1'b0, {(DATA_W-1){1'b1}}};
      end
      return res;
   endfunction

   logic signed [DATA_W-1:0] slope_r [SEG_N];
   logic signed [DATA_W-1:0] icpt_r  [SEG_N];

   logic                     en_s;
   logic signed [DATA_W:0]   d_s;
   cls_t                     cls_s;
   logic [ADDR_W-1:0]        idx_s;

   logic                     s1_vld_r;
   logic signed [DATA_W-1:0] s1_x_r;
   cls_t                     s1_cls_r;
   logic                     s1_hi_r;
   logic signed [DATA_W-1:0] s1_slope_r;
   logic signed [DATA_W-1:0] s1_icpt_r;

   logic                     s2_vld_r;
   logic signed [DATA_W-1:0] s2_x_r;
   cls_t                     s2_cls_r;
   logic                     s2_hi_r;
   logic signed [DATA_W-1:0] s2_icpt_r;
   logic signed [PROD_W-1:0] s2_p_r;

   logic signed [SUM_W-1:0]  r_s;
   logic [DATA_W-1:0]        y_nxt_s;
   logic                     out_valid_r;
   logic [DATA_W-1:0]        y_r;

   assign en_s          = !out_valid_r || bus.out_ready;
   assign bus.in_ready  = en_s;
   assign bus.out_valid = out_valid_r;
   assign bus.y         = y_r;

   assign d_s   = $signed({bus.x[DATA_W-1], bus.x}) - X_LO_EXT;
   assign idx_s = d_s[SEG_W_LOG2 +: ADDR_W];

   // S1 range classification of the incoming sample
   always_comb begin
      cls_s = CLS_IN;
      if (d_s[DATA_W]) begin
         cls_s = CLS_LO;
      end else if ($unsigned(d_s) >= RANGE_U) begin
         cls_s = CLS_HI;
      end else begin
         cls_s = CLS_IN;
      end
   end

   // Coefficient table; writes land regardless of stall, S1 reads see pre-write values
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SEG_N; i++) begin
            slope_r[i] <= {DATA_W{1'b0}};
            icpt_r[i]  <= {DATA_W{1'b0}};
         end
      end else if (bus.cfg_we) begin
         slope_r[bus.cfg_addr] <= bus.cfg_slope;
         icpt_r[bus.cfg_addr]  <= bus.cfg_icpt;
      end
   end

   // Product rounding (half toward +inf) happens before the intercept is added
   assign r_s = ((SUM_W'(s2_p_r) + RND) >>> FRAC_W) + SUM_W'(s2_icpt_r);

   // S3 result selection by class
   always_comb begin
      y_nxt_s = {DATA_W{1'b0}};
      case (s2_cls_r)
         CLS_IN:  y_nxt_s = sat_fn(r_s);
         CLS_LO:  y_nxt_s = {DATA_W{1'b0}};
         CLS_HI: begin
            if (s2_hi_r) begin
               y_nxt_s = ONE_Y;
            end else begin
               y_nxt_s = s2_x_r;
            end
         end
         default: y_nxt_s = {DATA_W{1'b0}};
      endcase
   end

   // Pipeline stages; everything advances together on en_s and freezes otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_r    <= 1'b0;
         s1_x_r      <= {DATA_W{1'b0}};
         s1_cls_r    <= CLS_IN;
         s1_hi_r     <= 1'b0;
         s1_slope_r  <= {DATA_W{1'b0}};
         s1_icpt_r   <= {DATA_W{1'b0}};
         s2_vld_r    <= 1'b0;
         s2_x_r      <= {DATA_W{1'b0}};
         s2_cls_r    <= CLS_IN;
         s2_hi_r     <= 1'b0;
         s2_icpt_r   <= {DATA_W{1'b0}};
         s2_p_r      <= {PROD_W{1'b0}};
         out_valid_r <= 1'b0;
         y_r         <= {DATA_W{1'b0}};
      end else if (en_s) begin
         s1_vld_r    <= bus.in_valid;
         s1_x_r      <= bus.x;
         s1_cls_r    <= cls_s;
         s1_hi_r     <= bus.hi_mode;
         s1_slope_r  <= slope_r[idx_s];
         s1_icpt_r   <= icpt_r[idx_s];
         s2_vld_r    <= s1_vld_r;
         s2_x_r      <= s1_x_r;
         s2_cls_r    <= s1_cls_r;
         s2_hi_r     <= s1_hi_r;
         s2_icpt_r   <= s1_icpt_r;
         s2_p_r      <= PROD_W'(s1_slope_r) * PROD_W'(s1_x_r);
         out_valid_r <= s2_vld_r;
         y_r         <= y_nxt_s;
      end
   end

`ifdef ACTFUNC_PLA_SAT_CNT_EN
   logic        s3_clip_r;
   logic [15:0] sat_cnt_r;

   assign sat_cnt = sat_cnt_r;

   // Clip flag travels with the S3 result; counter saturates at all-ones
   always_ff @(posedge clk) begin
      if (rst) begin
         s3_clip_r <= 1'b0;
         sat_cnt_r <= 16'h0000;
      end else begin
         if (en_s) begin
            s3_clip_r <= s2_vld_r && (s2_cls_r == CLS_IN) && !fits_fn(r_s);
         end else begin
            s3_clip_r <= s3_clip_r;
         end
         if (out_valid_r && bus.out_ready && s3_clip_r && (sat_cnt_r != 16'hFFFF)) begin
            sat_cnt_r <= sat_cnt_r + 16'd1;
         end else begin
            sat_cnt_r <= sat_cnt_r;
         end
      end
   end
`endif

endmodule

// File: tb/tb_actfunc_pla_pipe.sv
// Directed self-checking bench for actfunc_pla_pipe (default parameters).
module tb_actfunc_pla_pipe;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   actfunc_pla_pipe_if #(.DATA_W(16), .ADDR_W(4)) bus ();
`ifdef ACTFUNC_PLA_SAT_CNT_EN
   logic [15:0] sat_cnt;
`endif

   actfunc_pla_pipe #(
      .DATA_W(16), .FRAC_W(8), .SEG_N(16), .SEG_W_LOG2(8), .X_LO(-2048)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef ACTFUNC_PLA_SAT_CNT_EN
      ,
      .sat_cnt(sat_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cfg_write(input int a, input int s, input int i);
      @(negedge clk);
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = 4'(a);
      bus.cfg_slope = 16'(s);
      bus.cfg_icpt  = 16'(i);
      @(negedge clk);
      bus.cfg_we    = 1'b0;
   endtask

   task automatic run_single(input string tag, input int xv, input bit hm, input int exp);
      int lat;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.x        = 16'(xv);
      bus.hi_mode  = hm;
      #1 chk({tag, "_rdy"}, int'(bus.in_ready), 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, lat, 3);
      chk({tag, "_y"}, int'($signed(bus.y)), exp);
   endtask

   initial begin
      int     n;
      int     ys [2];
      int     sent;
      int     stalls;
      int     vcnt;
      bit     prev_stall;
      int     got [$];

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.x         = 16'd0;
      bus.hi_mode   = 1'b0;
      bus.out_ready = 1'b1;
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = 4'd0;
      bus.cfg_slope = 16'd0;
      bus.cfg_icpt  = 16'd0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_y", int'(bus.y), 0);
`ifdef ACTFUNC_PLA_SAT_CNT_EN
      chk("rst_sat_cnt", int'(sat_cnt), 0);
`endif
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", int'(bus.in_ready), 1);

      // main function, latency 3
      cfg_write(8, 192, 176);
      run_single("idx8", 128, 1'b0, 272);

      // out of range
      run_single("lo", -2304, 1'b0, 0);
      run_single("lo_edge", -2049, 1'b0, 0);
      run_single("hi_x", 2048, 1'b0, 2048);
      run_single("hi_one", 2048, 1'b1, 256);

      // range boundaries
      cfg_write(0, 0, 100);
      run_single("bound_lo", -2048, 1'b0, 100);
      cfg_write(15, 0, 300);
      run_single("bound_hi", 2047, 1'b0, 300);

      // rounding of the product: +1.5 -> 2, -1.5 -> -1
      cfg_write(9, 1, 0);
      run_single("rnd_pos", 384, 1'b0, 2);
      cfg_write(9, 65535, 0);
      run_single("rnd_neg", 384, 1'b0, -1);

      // saturation
      cfg_write(15, 32'h7FFF, 32'h7FFF);
      run_single("sat_pos", 1792, 1'b0, 32767);
`ifdef ACTFUNC_PLA_SAT_CNT_EN
      @(negedge clk);
      chk("sat_cnt_1", int'(sat_cnt), 1);
`endif
      cfg_write(0, 32'h7FFF, 32'h8000);
      run_single("sat_neg", -2048, 1'b0, -32768);
`ifdef ACTFUNC_PLA_SAT_CNT_EN
      @(negedge clk);
      chk("sat_cnt_2", int'(sat_cnt), 2);
`endif

      // write/read collision on idx 8
      cfg_write(8, 256, 0);
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.x         = 16'd128;
      bus.hi_mode   = 1'b0;
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = 4'd8;
      bus.cfg_slope = 16'd192;
      bus.cfg_icpt  = 16'd176;
      @(negedge clk);
      bus.cfg_we = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      n = 0;
      ys[0] = -99999;
      ys[1] = -99999;
      for (int k = 0; k < 10; k++) begin
         if (bus.out_valid) begin
            if (n < 2) ys[n] = int'($signed(bus.y));
            n++;
         end
         @(negedge clk);
      end
      chk("coll_count", n, 2);
      chk("coll_old", ys[0], 128);
      chk("coll_new", ys[1], 272);

      // backpressure: 6 samples, out_ready low for cycles 2..6
      sent       = 0;
      stalls     = 0;
      prev_stall = 1'b0;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         bus.out_ready = !(k >= 2 && k <= 6);
         bus.in_valid  = (sent < 6);
         bus.x         = 16'(2100 + sent);
         bus.hi_mode   = 1'b0;
         #1;
         if (prev_stall) chk("bp_hold_valid", int'(bus.out_valid), 1);
         if (bus.out_valid) chk("bp_y", int'($signed(bus.y)), 2100 + got.size());
         prev_stall = bus.out_valid && !bus.out_ready;
         if (prev_stall) begin
            stalls++;
            chk("bp_in_ready_low", int'(bus.in_ready), 0);
         end
         if (bus.out_valid && bus.out_ready) got.push_back(int'($signed(bus.y)));
         if (bus.in_valid && bus.in_ready) sent++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("bp_stall_cycles", stalls, 4);
      chk("bp_count", got.size(), 6);
      for (int i = 0; i < 6; i++) begin
         chk("bp_order", (i < got.size()) ? got[i] : -1, 2100 + i);
      end

      // reset with three samples in flight
      @(negedge clk);
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.in_valid = 1'b1;
         bus.x        = 16'(2200 + k);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      chk("mid_pre_valid", int'(bus.out_valid), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", int'(bus.out_valid), 0);
      chk("mid_rst_y", int'(bus.y), 0);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      vcnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus.out_valid) vcnt++;
      end
      chk("mid_no_stale", vcnt, 0);
`ifdef ACTFUNC_PLA_SAT_CNT_EN
      chk("mid_sat_cnt", int'(sat_cnt), 0);
`endif
      run_single("tbl_cleared", 128, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
